// File: rtl/pcie_mwr_tlp_gen.sv
// Memory Write TLP generator for the 64-bit 7-series AXIS TX port.
// Picks a 3DW/4DW header from the address and streams header plus payload under an arbiter grant.
module pcie_mwr_tlp_gen #(
  parameter int MAX_LEN_DW = 32
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic [15:0] cfg_completer_id,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [63:0] cmd_addr,
  input  logic [9:0]  cmd_len,
  input  logic [7:0]  cmd_tag,
  input  logic [63:0] pld_tdata,
  input  logic        pld_tvalid,
  output logic        pld_tready,
  output logic        s_axis_tx_req,
  input  logic        s_axis_tx_ack,
  input  logic        s_axis_tx_tready,
  output logic [63:0] s_axis_tx_tdata,
  output logic [7:0]  s_axis_tx_tkeep,
  output logic        s_axis_tx_tlast,
  output logic        s_axis_tx_tvalid,
  output logic        tx_src_dsc,
  output logic        busy,
  output logic        err_len,
  output logic        err_underrun
);

  // IDLE cmd wait | REQ arbiter request | HDR0/HDR1 header beats | DATA payload | REL wait for ack drop
  typedef enum logic [2:0] {IDLE, REQ, HDR0, HDR1, DATA, REL} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_addr_hi;
  logic [29:0] r_addr_lo;
  logic [9:0]  r_len, r_rem, w_dec;
  logic [7:0]  r_tag;
  logic        r_is4dw;
  logic [31:0] r_hold;
  logic        r_err_len, r_err_underrun;
  logic [31:0] w_dw0, w_dw1, w_dw2, w_dw3;
  logic [7:0]  w_keep_last;
  logic        w_need_pld, w_fire, w_len_ok, w_unused;

  assign w_unused     = ^cmd_addr[1:0];
  assign w_len_ok     = (cmd_len != 10'd0) && (cmd_len <= 10'(MAX_LEN_DW));
  assign w_dw0        = {1'b0, (r_is4dw ? 2'b11 : 2'b10), 19'b0, r_len};
  assign w_dw1        = {cfg_completer_id, r_tag, ((r_len == 10'd1) ? 4'h0 : 4'hF), 4'hF};
  assign w_dw2        = r_is4dw ? r_addr_hi : {r_addr_lo, 2'b00};
  assign w_dw3        = {r_addr_lo, 2'b00};
  // odd total DW count (header + payload) leaves the upper half of the last beat empty
  assign w_keep_last  = (r_is4dw ? r_len[0] : ~r_len[0]) ? 8'h0F : 8'hFF;
  assign w_fire       = s_axis_tx_tvalid && s_axis_tx_tready;
  assign tx_src_dsc   = 1'b0;
  assign busy         = (r_state != IDLE);
  assign err_len      = r_err_len;
  assign err_underrun = r_err_underrun;

  always_comb begin
    w_next           = r_state;
    cmd_ready        = 1'b0;
    s_axis_tx_req    = 1'b0;
    s_axis_tx_tvalid = 1'b0;
    s_axis_tx_tdata  = 64'h0;
    s_axis_tx_tkeep  = 8'h00;
    s_axis_tx_tlast  = 1'b0;
    pld_tready       = 1'b0;
    w_need_pld       = 1'b0;
    w_dec            = 10'd0;
    case (r_state)
      IDLE: begin
        cmd_ready = cmd_valid;
        if (cmd_valid && w_len_ok) w_next = REQ;
      end
      REQ: begin
        s_axis_tx_req = 1'b1;
        if (s_axis_tx_ack) w_next = HDR0;
      end
      HDR0: begin
        s_axis_tx_req    = 1'b1;
        s_axis_tx_tvalid = 1'b1;
        s_axis_tx_tdata  = {w_dw1, w_dw0};
        s_axis_tx_tkeep  = 8'hFF;
        if (s_axis_tx_tready) w_next = HDR1;
      end
      HDR1: begin
        s_axis_tx_req = 1'b1;
        if (r_is4dw) begin
          s_axis_tx_tvalid = 1'b1;
          s_axis_tx_tdata  = {w_dw3, w_dw2};
          s_axis_tx_tkeep  = 8'hFF;
          if (s_axis_tx_tready) w_next = DATA;
        end else begin
          w_need_pld       = 1'b1;
          pld_tready       = s_axis_tx_tready;
          s_axis_tx_tvalid = pld_tvalid;
          s_axis_tx_tdata  = {pld_tdata[31:0], w_dw2};
          s_axis_tx_tlast  = (r_rem == 10'd1);
          s_axis_tx_tkeep  = (r_rem == 10'd1) ? w_keep_last : 8'hFF;
          w_dec            = 10'd1;
          if (w_fire) w_next = (r_rem == 10'd1) ? REL : DATA;
        end
      end
      DATA: begin
        s_axis_tx_req = 1'b1;
        if (r_is4dw) begin
          w_need_pld       = 1'b1;
          pld_tready       = s_axis_tx_tready;
          s_axis_tx_tvalid = pld_tvalid;
          s_axis_tx_tdata  = pld_tdata;
          s_axis_tx_tlast  = (r_rem <= 10'd2);
          s_axis_tx_tkeep  = (r_rem <= 10'd2) ? w_keep_last : 8'hFF;
          w_dec            = (r_rem == 10'd1) ? 10'd1 : 10'd2;
        end else if (r_rem == 10'd1) begin
          // only the held upper DW of the previous word is left
          s_axis_tx_tvalid = 1'b1;
          s_axis_tx_tdata  = {32'h0, r_hold};
          s_axis_tx_tlast  = 1'b1;
          s_axis_tx_tkeep  = w_keep_last;
          w_dec            = 10'd1;
        end else begin
          w_need_pld       = 1'b1;
          pld_tready       = s_axis_tx_tready;
          s_axis_tx_tvalid = pld_tvalid;
          s_axis_tx_tdata  = {pld_tdata[31:0], r_hold};
          s_axis_tx_tlast  = (r_rem == 10'd2);
          s_axis_tx_tkeep  = (r_rem == 10'd2) ? w_keep_last : 8'hFF;
          w_dec            = 10'd2;
        end
        if (w_fire && s_axis_tx_tlast) w_next = REL;
      end
      REL: begin
        if (!s_axis_tx_ack) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (w_fire && s_axis_tx_tlast) s_axis_tx_req = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      r_state        <= IDLE;
      r_addr_hi      <= '0;
      r_addr_lo      <= '0;
      r_len          <= '0;
      r_rem          <= '0;
      r_tag          <= '0;
      r_is4dw        <= 1'b0;
      r_hold         <= '0;
      r_err_len      <= 1'b0;
      r_err_underrun <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && cmd_valid) begin
        r_addr_hi <= cmd_addr[63:32];
        r_addr_lo <= cmd_addr[31:2];
        r_len     <= cmd_len;
        r_rem     <= cmd_len;
        r_tag     <= cmd_tag;
        r_is4dw   <= (cmd_addr[63:32] != 32'h0);
        if (!w_len_ok) r_err_len <= 1'b1;
      end
      if (w_need_pld && !pld_tvalid) r_err_underrun <= 1'b1;
      if (w_fire) r_rem <= r_rem - w_dec;
      if (w_fire && w_need_pld && !r_is4dw) r_hold <= pld_tdata[63:32];
    end
  end

endmodule

// File: tb/tb_pcie_mwr_tlp_gen.sv
// Bench for pcie_mwr_tlp_gen: a DW-stream packing model predicts every beat,
// a negedge monitor compares accepted beats and stall stability, directed tests pin literals.
module tb_pcie_mwr_tlp_gen;
  localparam int MAX_LEN = 32;

  logic        clk;
  logic        sys_rst_n;
  logic [15:0] cfg_completer_id;
  logic        cmd_valid, cmd_ready;
  logic [63:0] cmd_addr;
  logic [9:0]  cmd_len;
  logic [7:0]  cmd_tag;
  logic [63:0] pld_tdata;
  logic        pld_tvalid, pld_tready;
  logic        s_axis_tx_req, s_axis_tx_ack, s_axis_tx_tready;
  logic [63:0] s_axis_tx_tdata;
  logic [7:0]  s_axis_tx_tkeep;
  logic        s_axis_tx_tlast, s_axis_tx_tvalid;
  logic        tx_src_dsc, busy, err_len, err_underrun;

  pcie_mwr_tlp_gen #(.MAX_LEN_DW(MAX_LEN)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .cfg_completer_id(cfg_completer_id),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_tag(cmd_tag),
    .pld_tdata(pld_tdata), .pld_tvalid(pld_tvalid), .pld_tready(pld_tready),
    .s_axis_tx_req(s_axis_tx_req), .s_axis_tx_ack(s_axis_tx_ack),
    .s_axis_tx_tready(s_axis_tx_tready), .s_axis_tx_tdata(s_axis_tx_tdata),
    .s_axis_tx_tkeep(s_axis_tx_tkeep), .s_axis_tx_tlast(s_axis_tx_tlast),
    .s_axis_tx_tvalid(s_axis_tx_tvalid), .tx_src_dsc(tx_src_dsc), .busy(busy),
    .err_len(err_len), .err_underrun(err_underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] pld_mem [0:15];
  logic [63:0] cap_d [0:255];
  logic [7:0]  cap_k [0:255];
  logic        cap_l [0:255];
  int          cap_n = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] kmask(input logic [7:0] k);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  // Model: list every DW of the TLP in wire order, then pack pairs into beats.
  task automatic model_tlp(input logic [63:0] addr, input int len, input logic [7:0] tag);
    logic [31:0] dws[$];
    logic [9:0]  l10;
    logic [63:0] w;
    bit          is4;
    beat_t       b;
    int          n;
    l10 = len[9:0];
    is4 = (addr[63:32] != 32'h0);
    dws.push_back({1'b0, (is4 ? 2'b11 : 2'b10), 19'b0, l10});
    dws.push_back({cfg_completer_id, tag, ((len == 1) ? 4'h0 : 4'hF), 4'hF});
    if (is4) dws.push_back(addr[63:32]);
    dws.push_back({addr[31:2], 2'b00});
    for (int i = 0; i < len; i++) begin
      w = pld_mem[i/2];
      dws.push_back((i % 2 == 1) ? w[63:32] : w[31:0]);
    end
    n = dws.size();
    for (int j = 0; j < n; j += 2) begin
      b.d = {((j + 1 < n) ? dws[j+1] : 32'h0), dws[j]};
      b.k = (j + 1 < n) ? 8'hFF : 8'h0F;
      b.l = (j + 2 >= n);
      exp_q.push_back(b);
    end
  endtask

  // Compare process
  logic        prev_stall;
  logic [63:0] prev_d;
  logic [7:0]  prev_k;
  logic        prev_l;
  logic        in_pkt;
  initial begin
    beat_t e;
    prev_stall = 1'b0;
    in_pkt     = 1'b0;
    forever begin
      @(negedge clk);
      if (!sys_rst_n) begin
        prev_stall = 1'b0;
        in_pkt     = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_tvalid", s_axis_tx_tvalid, 1'b1);
          chk("stall_tdata", s_axis_tx_tdata, prev_d);
          chk("stall_tkeep", s_axis_tx_tkeep, prev_k);
          chk("stall_tlast", s_axis_tx_tlast, prev_l);
        end
        if (in_pkt && !s_axis_tx_tvalid) chk("tvalid_low_without_gap", pld_tvalid, 1'b0);
        if (cmd_ready) chk("cmd_ready_outside_idle", busy, 1'b0);
        if (s_axis_tx_tvalid && s_axis_tx_tready) begin
          cap_d[cap_n & 255] = s_axis_tx_tdata;
          cap_k[cap_n & 255] = s_axis_tx_tkeep;
          cap_l[cap_n & 255] = s_axis_tx_tlast;
          cap_n++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_beat: got %h, want no beat", s_axis_tx_tdata);
          end else begin
            e = exp_q.pop_front();
            chk("beat_tdata", s_axis_tx_tdata & kmask(e.k), e.d & kmask(e.k));
            chk("beat_tkeep", s_axis_tx_tkeep, e.k);
            chk("beat_tlast", s_axis_tx_tlast, e.l);
            chk("src_dsc", tx_src_dsc, 1'b0);
            if (s_axis_tx_tlast) chk("req_drop_on_last", s_axis_tx_req, 1'b0);
          end
        end
        if (s_axis_tx_tvalid) in_pkt = 1'b1;
        if (s_axis_tx_tvalid && s_axis_tx_tready && s_axis_tx_tlast) in_pkt = 1'b0;
        prev_stall = s_axis_tx_tvalid && !s_axis_tx_tready;
        prev_d = s_axis_tx_tdata;
        prev_k = s_axis_tx_tkeep;
        prev_l = s_axis_tx_tlast;
      end
    end
  end

  task automatic drive_pld(input int pidx, inout int gap_rem);
    if (gap_rem > 0) begin
      pld_tvalid = 1'b0;
      gap_rem--;
    end else begin
      pld_tvalid = 1'b1;
      pld_tdata  = pld_mem[pidx % 16];
    end
  endtask

  task automatic run_tlp(input logic [63:0] addr, input int len, input logic [7:0] tag,
                         input bit toggle, input int gap_at, input int gap_len,
                         input int abort_beats);
    int pidx, gap_rem, consumed, beats;
    bit acc, pf, bf, rq, seen_last, done, aborted;
    model_tlp(addr, len, tag);
    pidx = 0; consumed = 0; beats = 0;
    acc = 0; seen_last = 0; done = 0; aborted = 0;
    gap_rem = (gap_at == 0) ? gap_len : 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len[9:0];
    cmd_tag   = tag;
    s_axis_tx_tready = 1'b1;
    drive_pld(pidx, gap_rem);
    for (int c = 0; c < 2000 && !done && !aborted; c++) begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) acc = 1;
      pf = pld_tvalid && pld_tready;
      bf = s_axis_tx_tvalid && s_axis_tx_tready;
      if (bf) beats++;
      if (bf && s_axis_tx_tlast) seen_last = 1;
      rq = s_axis_tx_req;
      if (seen_last && !busy) done = 1;
      if (abort_beats > 0 && beats >= abort_beats) aborted = 1;
      if (!done && !aborted) begin
        @(posedge clk); #1;
        if (acc) cmd_valid = 1'b0;
        s_axis_tx_ack = rq;
        if (toggle) s_axis_tx_tready = ~s_axis_tx_tready;
        if (pf) begin
          pidx++;
          consumed++;
          if (pidx == gap_at) gap_rem = gap_len;
        end
        drive_pld(pidx, gap_rem);
      end
    end
    if (!done && !aborted) begin
      n_cmp++;
      n_fail++;
      $display("FAIL tlp_timeout: got %0d beats, want a complete TLP of len %0d", beats, len);
    end else if (done) begin
      chk("pld_words_consumed", consumed, (len + 1) / 2);
      chk("model_drained", exp_q.size(), 0);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_req"}, s_axis_tx_req, 1'b0);
    chk({tag, "_tvalid"}, s_axis_tx_tvalid, 1'b0);
    chk({tag, "_tlast"}, s_axis_tx_tlast, 1'b0);
    chk({tag, "_tkeep"}, s_axis_tx_tkeep, 8'h00);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b0);
    chk({tag, "_pld_tready"}, pld_tready, 1'b0);
    chk({tag, "_err_len"}, err_len, 1'b0);
    chk({tag, "_err_underrun"}, err_underrun, 1'b0);
  endtask

  task automatic bad_cmd(input logic [9:0] len, output bit saw, inout bit req_seen);
    saw = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_len   = len;
    cmd_addr  = 64'h0000_0000_0000_0100;
    for (int c = 0; c < 10 && !saw; c++) begin
      @(negedge clk);
      if (cmd_ready) saw = 1;
      if (s_axis_tx_req) req_seen = 1;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (s_axis_tx_req) req_seen = 1;
    end
  endtask

  initial begin
    int b;
    bit saw, req_seen;
    sys_rst_n        = 1'b0;
    cfg_completer_id = 16'h0100;
    cmd_valid        = 1'b0;
    cmd_addr         = '0;
    cmd_len          = '0;
    cmd_tag          = '0;
    pld_tdata        = '0;
    pld_tvalid       = 1'b0;
    s_axis_tx_ack    = 1'b0;
    s_axis_tx_tready = 1'b1;
    for (int i = 0; i < 16; i++) pld_mem[i] = 64'h0;
    repeat (2) @(posedge clk);
    #1 sys_rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset");

    // 3DW, len 1
    pld_mem[0] = 64'hBBBB_BBBB_AAAA_AAAA;
    b = cap_n;
    run_tlp(64'h0000_0000_1000_0040, 1, 8'h05, 0, -1, 0, 0);
    chk("t1_beat0", cap_d[b], 64'h0100_050F_4000_0001);
    chk("t1_beat1", cap_d[b+1], 64'hAAAA_AAAA_1000_0040);
    chk("t1_keep1", cap_k[b+1], 8'hFF);
    chk("t1_last1", cap_l[b+1], 1'b1);
    chk("t1_beats", cap_n - b, 2);

    // 4DW, len 4
    pld_mem[0] = 64'h2222_2222_1111_1111;
    pld_mem[1] = 64'h4444_4444_3333_3333;
    b = cap_n;
    run_tlp(64'h0000_0001_0000_0100, 4, 8'h11, 0, -1, 0, 0);
    chk("t2_dw0", cap_d[b][31:0], 32'h6000_0004);
    chk("t2_beat1", cap_d[b+1], 64'h0000_0100_0000_0001);
    chk("t2_beat2", cap_d[b+2], 64'h2222_2222_1111_1111);
    chk("t2_beat3", cap_d[b+3], 64'h4444_4444_3333_3333);
    chk("t2_keep3", cap_k[b+3], 8'hFF);

    // 3DW, len 2: trailing held DW alone
    pld_mem[0] = 64'hDDDD_DDDD_CCCC_CCCC;
    b = cap_n;
    run_tlp(64'h0000_0000_2000_0008, 2, 8'h22, 0, -1, 0, 0);
    chk("t3_beat1", cap_d[b+1], 64'hCCCC_CCCC_2000_0008);
    chk("t3_beat2", cap_d[b+2], 64'h0000_0000_DDDD_DDDD);
    chk("t3_keep2", cap_k[b+2], 8'h0F);
    chk("t3_last2", cap_l[b+2], 1'b1);
    chk("t3_no_underrun", err_underrun, 1'b0);
    chk("t3_no_err_len", err_len, 1'b0);

    // 3DW len 8, tready toggling, 3-cycle payload gap in DATA
    for (int i = 0; i < 4; i++) pld_mem[i] = {32'hA000_0000 + 32'(2*i+1), 32'hA000_0000 + 32'(2*i)};
    run_tlp(64'h0000_0000_3000_0010, 8, 8'h33, 1, 2, 3, 0);
    chk("t4_underrun", err_underrun, 1'b1);

    // 4DW len 5 with tready toggling: odd total, 0F on the final beat
    for (int i = 0; i < 3; i++) pld_mem[i] = {32'hB000_0000 + 32'(2*i+1), 32'hB000_0000 + 32'(2*i)};
    b = cap_n;
    run_tlp(64'h0000_0002_0000_0200, 5, 8'h44, 1, -1, 0, 0);
    chk("t5_keep4", cap_k[b+4], 8'h0F);
    chk("t5_beat4_lo", cap_d[b+4][31:0], 32'hB000_0004);

    // illegal lengths
    req_seen = 0;
    bad_cmd(10'd0, saw, req_seen);
    chk("len0_cmd_ready", saw, 1'b1);
    chk("len0_err_len", err_len, 1'b1);
    bad_cmd(10'(MAX_LEN + 1), saw, req_seen);
    chk("lenmax1_cmd_ready", saw, 1'b1);
    chk("bad_len_no_req", req_seen, 1'b0);
    chk("bad_len_not_busy", busy, 1'b0);

    // legal command after the rejects
    pld_mem[0] = 64'h5555_5555_6666_6666;
    pld_mem[1] = 64'h7777_7777_8888_8888;
    b = cap_n;
    run_tlp(64'h0000_0000_0000_1004, 3, 8'h55, 0, -1, 0, 0);
    chk("t7_dw0", cap_d[b][31:0], 32'h4000_0003);
    chk("t7_beat1", cap_d[b+1], 64'h6666_6666_0000_1004);
    chk("t7_err_len_sticky", err_len, 1'b1);

    // reset in the middle of DATA
    for (int i = 0; i < 4; i++) pld_mem[i] = {32'hC000_0000 + 32'(2*i+1), 32'hC000_0000 + 32'(2*i)};
    run_tlp(64'h0000_0000_4000_0020, 8, 8'h66, 0, -1, 0, 3);
    @(posedge clk); #1;
    sys_rst_n  = 1'b0;
    pld_tvalid = 1'b0;
    @(posedge clk); #1;
    sys_rst_n        = 1'b1;
    s_axis_tx_ack    = 1'b0;
    s_axis_tx_tready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_idle_outputs("mid_reset");
    repeat (2) @(negedge clk);

    // fresh 4DW TLP after reset; address low bits ignored
    pld_mem[0] = 64'h9999_9999_8888_8888;
    b = cap_n;
    run_tlp(64'hFFFF_0000_0000_0013, 2, 8'h77, 0, -1, 0, 0);
    chk("t9_beat0", cap_d[b], 64'h0100_77FF_6000_0002);
    chk("t9_beat1", cap_d[b+1], 64'h0000_0010_FFFF_0000);
    chk("t9_beat2", cap_d[b+2], 64'h9999_9999_8888_8888);
    chk("t9_last2", cap_l[b+2], 1'b1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pcie_mwr_tlp_gen.md
Name: pcie_mwr_tlp_gen

Overview:
- Upstream producer for the PCIe TX arbiter. Builds Memory Write TLPs on the 64-bit 7-series AXIS TX interface.
- Accepts a write command (address, DW length, tag) and a 64-bit payload stream.
- Requests the arbiter with req/ack, emits header plus payload back-to-back, then releases the grant.
- Selects a 3DW or 4DW header automatically from the address.

Parameters:
- MAX_LEN_DW, 32, largest accepted payload in DW (128 B MPS); legal range 1..1023.

Ports:
- clk, in, 1, sole clock.
- sys_rst_n, in, 1, synchronous active-low reset.
- cfg_completer_id, in, 16, requester ID placed in DW1[31:16].
- cmd_valid, in, 1, command present.
- cmd_ready, out, 1, command accepted (one-cycle pulse).
- cmd_addr, in, 64, byte address; bits [1:0] ignored.
- cmd_len, in, 10, payload length in DW.
- cmd_tag, in, 8, TLP tag.
- pld_tdata, in, 64, payload word; lower DW is first in order.
- pld_tvalid, in, 1, payload word valid.
- pld_tready, out, 1, payload word consumed.
- s_axis_tx_req, out, 1, request to arbiter.
- s_axis_tx_ack, in, 1, grant from arbiter.
- s_axis_tx_tready, in, 1, core ready.
- s_axis_tx_tdata, out, 64, TLP data; DW0 in [31:0].
- s_axis_tx_tkeep, out, 8, byte enables.
- s_axis_tx_tlast, out, 1, final beat.
- s_axis_tx_tvalid, out, 1, beat valid.
- tx_src_dsc, out, 1, constant 0.
- busy, out, 1, high in any state except IDLE.
- err_len, out, 1, sticky: a command was rejected for illegal length.
- err_underrun, out, 1, sticky: payload stalled mid-TLP.

Behaviour:
- Reset (sys_rst_n low at a clk edge): state returns to IDLE, and all outputs go to 0 (tkeep 8'h00). This applies mid-packet too; the arbiter then drops ack because req is low.
- States: IDLE, REQ, HDR0, HDR1, DATA, REL.
- IDLE: when cmd_valid is high, pulse cmd_ready for one cycle and latch addr, len and tag.
  - If len==0 or len>MAX_LEN_DW: set err_len, stay in IDLE, send nothing.
  - Otherwise: set is4dw = (addr[63:32]!=0), set remaining-DW counter = len, go to REQ.
- REQ: hold req=1. The cycle after ack is sampled high, go to HDR0.
- Header fields:
  - DW0: fmt = is4dw?2'b11:2'b10, type 5'b00000, TC/TD/EP/attr 0, length = len.
  - DW1: {cfg_completer_id, tag, lastBE, firstBE=4'hF}, with lastBE = (len==1)?4'h0:4'hF.
  - Addressing: 3DW uses DW2 = {addr[31:2],2'b00}; 4DW uses DW2 = addr[63:32] and DW3 = {addr[31:2],2'b00}.
- HDR0: tvalid=1, tdata={DW1,DW0}, tkeep FF. Advance on tready.
- HDR1, 3DW: beat = {pld[31:0], DW2}. This needs pld_tvalid; pld_tready=tready. Store pld[63:32] in a hold register.
- HDR1, 4DW: beat = {DW3, DW2}; no payload consumed.
- DATA, 4DW: beat = pld word directly.
- DATA, 3DW: beat = {pld[31:0], hold}. Refill hold with pld[63:32]. If only the held DW remains, emit {32'h0, hold} without consuming.
- Counter: decrement by DWs emitted per accepted beat.
- Final beat: tlast=1. tkeep=8'h0F if the total DW count (hdr+len) is odd, else 8'hFF.
- Payload accounting: exactly ceil(len/2) words consumed per TLP. For odd len, the unused upper DW of the last word is dropped.
- Length 1, 3DW: the TLP ends at HDR1 with tlast; no DATA state.
- Underrun: tvalid is held at 1 throughout HDR0..last beat, except when a payload word is required and pld_tvalid=0.
  - In that case tvalid=0 and err_underrun is set.
  - Resume on the same beat when pld_tvalid returns.
- Beat stability: tdata, tkeep and tlast stay stable while tvalid=1 and tready=0.
- REL: tlast accepted → req=0 in the same transfer cycle.
  - Stay in REL until ack is sampled low, then go to IDLE.
  - cmd_ready is never asserted outside IDLE.
- Latency: cmd accept to req is 1 cycle. With tready=1 and payload present, ack to first tvalid is 1 cycle, and the TLP is then contiguous.

Test Plan:
- Ack tied 1 cycle after req, tready=1. 3DW: addr=64'h0000_0000_1000_0040, len=1, tag=8'h05, id=16'h0100, pld=64'hBBBB_BBBB_AAAA_AAAA.
  - Expect two beats: {32'h0100_0500|lastBE0/firstBE F → 32'h0100_050F, 32'h4000_0001}, then {32'hAAAA_AAAA, 32'h1000_0040} with tlast and tkeep FF.
  - Upper DW dropped; exactly 1 pld_tready.
- 4DW: addr=64'h0000_0001_0000_0100, len=4, words W0,W1.
  - Expect 4 beats; beat1={32'h0000_0100, 32'h0000_0001}; beats 2-3 = W0,W1.
  - tkeep FF on last beat; DW0=32'h6000_0004.
- 3DW len=2: last beat = {0, W0[63:32]}, tkeep 0F, tlast. Exactly 1 word consumed.
- tready toggling 1/0 each cycle plus a 3-cycle pld_tvalid gap in DATA.
  - Beats held stable across stalls; tvalid low only during the gap; err_underrun=1; payload order preserved.
- cmd_len=0, then cmd_len=MAX_LEN_DW+1.
  - cmd_ready pulses each time, err_len=1, req never asserted.
  - A following legal command is sent normally.
- sys_rst_n low for 1 cycle during DATA.
  - Next cycle req, tvalid, tlast, busy and cmd_ready are 0 and errors are cleared.
  - A new command after reset produces a correct complete TLP.
